spi_bus_arbiter: RTL and testbench

//  Shares one 8-bit SPI master (CPOL=0/CPHA=0 byte engine) between NUM_REQ requesters.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_rr_picker.sv | 33 +++
 rtl/spi_bus_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI bus arbiter: FSM state encoding, byte width and
// round-robin pointer helper.
package spi_pkg;

   localparam int SPI_BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_EN,
      XFER,
      DONE,
      HOLD,
      GAP
   } arb_state_t;

   function automatic int rr_next(input int g, input int n);
      return (g + 1 >= n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin select: first set request at or after the pointer,
// wrapping, returned as one-hot grant plus index.
module spi_rr_picker
   import spi_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDW-1:0]     id_o,
   output logic               any_o
);

   int idx;

   always_comb begin
      gnt_o = '0;
      id_o  = '0;
      any_o = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr_i) + k) % NUM_REQ;
         if (!any_o && req_i[IDW'(idx)]) begin
            any_o              = 1'b1;
            id_o               = IDW'(idx);
            gnt_o[IDW'(idx)]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin sharing of one 8-bit SPI byte engine between NUM_REQ requesters with
// burst-held chip selects. Optional per-byte watchdog: define SPI_ARB_WATCHDOG_EN.
module spi_bus_arbiter
   import spi_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int CS_GAP    = 2,
   parameter  int WD_CYCLES = 512,
   localparam int IDW       = $clog2(NUM_REQ),
   localparam int GW        = $clog2(CS_GAP + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*SPI_BYTE_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          rsp_valid,
   output logic [SPI_BYTE_W-1:0]         rsp_data,
   output logic [IDW-1:0]                rsp_id,
   output logic                          rsp_err,
   output logic [NUM_REQ-1:0]            cs_n,
   output logic                          drv_start,
   output logic [SPI_BYTE_W-1:0]         drv_tx,
   input  logic                          drv_en,
   input  logic [SPI_BYTE_W-1:0]         drv_rx
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || CS_GAP < 1 || WD_CYCLES < 2) begin : g_bad_param
      $error("spi_bus_arbiter: parameter out of range");
   end

   arb_state_t            state_q, state_d;
   logic [IDW-1:0]        gnt_q, gnt_d, ptr_q, ptr_d, rsp_id_q, rsp_id_d, ptr_after;
   logic                  last_q, last_d, drv_start_q, drv_start_d, rsp_valid_q, rsp_valid_d;
   logic [NUM_REQ-1:0]    cs_n_q, cs_n_d, req_ready_q, req_ready_d;
   logic [SPI_BYTE_W-1:0] drv_tx_q, drv_tx_d, rsp_data_q, rsp_data_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic                  enter_start;
   logic [NUM_REQ-1:0]    pick_gnt;
   logic [IDW-1:0]        pick_id;
   logic                  pick_any;

`ifdef SPI_ARB_WATCHDOG_EN
   localparam int WDW = $clog2(WD_CYCLES);
   logic [WDW-1:0] wd_q, wd_d;
   logic           rsp_err_q, rsp_err_d;
`endif

   spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .id_o  (pick_id),
      .any_o (pick_any)
   );

   assign ptr_after = IDW'(rr_next(int'(gnt_q), NUM_REQ));

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      ptr_d       = ptr_q;
      last_d      = last_q;
      cs_n_d      = cs_n_q;
      req_ready_d = '0;
      drv_start_d = 1'b0;
      drv_tx_d    = drv_tx_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      gap_d       = gap_q;
      enter_start = 1'b0;
`ifdef SPI_ARB_WATCHDOG_EN
      wd_d        = wd_q;
      rsp_err_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d       = pick_id;
               cs_n_d      = ~pick_gnt;
               enter_start = 1'b1;
            end
         end
         START:   state_d = WAIT_EN;
         WAIT_EN: if (drv_en) state_d = XFER;
         XFER: begin
            if (!drv_en) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = drv_rx;
               rsp_id_d    = gnt_q;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (last_q) begin
               cs_n_d  = '1;
               ptr_d   = ptr_after;
               gap_d   = GW'(CS_GAP - 1);
               state_d = GAP;
            end else begin
               state_d = HOLD;
            end
         end
         // Bus stays owned here; other requesters are not looked at until the burst ends.
         HOLD: if (req_valid[gnt_q]) enter_start = 1'b1;
         GAP: begin
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Start outputs are registered so they line up exactly with the START cycle.
      if (enter_start) begin
         state_d              = START;
         drv_start_d          = 1'b1;
         drv_tx_d             = req_data[SPI_BYTE_W*gnt_d +: SPI_BYTE_W];
         req_ready_d[gnt_d]   = 1'b1;
         last_d               = req_last[gnt_d];
`ifdef SPI_ARB_WATCHDOG_EN
         wd_d                 = '0;
`endif
      end

`ifdef SPI_ARB_WATCHDOG_EN
      if (state_q == WAIT_EN || state_q == XFER) begin
         wd_d = wd_q + 1'b1;
         if (wd_q == WDW'(WD_CYCLES - 1) && !(state_q == XFER && !drv_en)) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_id_d    = gnt_q;
            cs_n_d      = '1;
            ptr_d       = ptr_after;
            gap_d       = GW'(CS_GAP - 1);
            state_d     = GAP;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         ptr_q       <= '0;
         last_q      <= 1'b0;
         cs_n_q      <= '1;
         req_ready_q <= '0;
         drv_start_q <= 1'b0;
         drv_tx_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         gap_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         ptr_q       <= ptr_d;
         last_q      <= last_d;
         cs_n_q      <= cs_n_d;
         req_ready_q <= req_ready_d;
         drv_start_q <= drv_start_d;
         drv_tx_q    <= drv_tx_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         gap_q       <= gap_d;
      end
   end

`ifdef SPI_ARB_WATCHDOG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q      <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         rsp_err_q <= rsp_err_d;
      end
   end
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign cs_n      = cs_n_q;
   assign req_ready = req_ready_q;
   assign drv_start = drv_start_q;
   assign drv_tx    = drv_tx_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter with a behavioural SPI byte engine (MISO = MOSI ^ 8'h99).
module tb_spi_bus_arbiter;

   localparam int NUM_REQ = 4;
   localparam int CS_GAP  = 2;
   localparam int WD_CYC  = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data  = '0;
   logic [3:0]  req_last  = '0;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_id;
   logic        rsp_err;
   logic [3:0]  cs_n;
   logic        drv_start;
   logic [7:0]  drv_tx;
   logic        drv_en;
   logic [7:0]  drv_rx;

   spi_bus_arbiter #(.NUM_REQ(NUM_REQ), .CS_GAP(CS_GAP), .WD_CYCLES(WD_CYC)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .rsp_err(rsp_err), .cs_n(cs_n), .drv_start(drv_start), .drv_tx(drv_tx),
      .drv_en(drv_en), .drv_rx(drv_rx)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [7:0] d; logic [1:0] id; logic err; } exp_t;
   exp_t exp_tx[$];
   exp_t exp_rsp[$];

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Engine model: 1 cycle after start, drv_en high for 8 cycles, rx valid as it falls.
   bit         eng_stall = 1'b0;
   logic       eng_busy;
   int         eng_cnt;
   logic [7:0] eng_tx;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         drv_en <= 1'b0; drv_rx <= '0; eng_busy <= 1'b0; eng_cnt <= 0; eng_tx <= '0;
      end else if (!eng_busy) begin
         if (drv_start && !eng_stall) begin
            eng_busy <= 1'b1; eng_cnt <= 0; eng_tx <= drv_tx;
         end
      end else begin
         eng_cnt <= eng_cnt + 1;
         if (eng_cnt == 0) drv_en <= 1'b1;
         else if (eng_cnt == 8) begin
            drv_en <= 1'b0; drv_rx <= eng_tx ^ 8'h99; eng_busy <= 1'b0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a start or a response.
   logic [3:0] cur_cs = 4'hF;
   int         hi_cnt = 0;
   exp_t       e;
   always @(negedge clk) begin
      if (!rst) begin
         if (drv_start) begin
            if (exp_tx.size() == 0) chk("tx_unexpected", drv_tx, 32'hFFFF_FFFF);
            else begin
               e = exp_tx.pop_front();
               cur_cs = ~(4'b0001 << e.id);
               chk("drv_tx", drv_tx, e.d);
               chk("cs_at_start", cs_n, cur_cs);
               chk("req_ready_onehot", req_ready, 4'b0001 << e.id);
            end
         end
         if (drv_en) chk("cs_during_byte", cs_n, cur_cs);
         if (rsp_valid) begin
            if (exp_rsp.size() == 0) chk("rsp_unexpected", rsp_data, 32'hFFFF_FFFF);
            else begin
               e = exp_rsp.pop_front();
               chk("rsp_data", rsp_data, e.d);
               chk("rsp_id", rsp_id, e.id);
               chk("rsp_err", rsp_err, e.err);
            end
         end
      end
      if (cs_n == 4'hF) hi_cnt++;
      else begin
         if (hi_cnt > 0) chk("cs_gap_min", hi_cnt >= CS_GAP, 1);
         hi_cnt = 0;
      end
   end

   task automatic exp_byte(input int id, input logic [7:0] tx, input logic err);
      exp_tx.push_back('{d: tx, id: 2'(id), err: 1'b0});
      exp_rsp.push_back('{d: err ? 8'h00 : (tx ^ 8'h99), id: 2'(id), err: err});
   endtask

   task automatic send(input int id, input logic [7:0] b, input logic last);
      int n = 0;
      req_data[8*id +: 8] = b;
      req_last[id]        = last;
      req_valid[id]       = 1'b1;
      do begin @(negedge clk); n++; end while (!req_ready[id] && n < 3000);
      chk("req_ready_seen", req_ready[id], 1);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      req_last[id]  = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (!(exp_tx.size() == 0 && exp_rsp.size() == 0 && cs_n == 4'hF) && n < 3000) begin
         @(negedge clk); n++;
      end
      chk({nm, "_complete"}, n < 3000, 1);
      repeat (4) @(negedge clk);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_cs_n"}, cs_n, 4'hF);
      chk({nm, "_req_ready"}, req_ready, 0);
      chk({nm, "_rsp_valid"}, rsp_valid, 0);
      chk({nm, "_rsp_err"}, rsp_err, 0);
      chk({nm, "_drv_start"}, drv_start, 0);
      chk({nm, "_rsp_data"}, rsp_data, 0);
      chk({nm, "_drv_tx"}, drv_tx, 0);
      chk({nm, "_rsp_id"}, rsp_id, 0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 chk_reset_outs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single byte from req0.
      exp_byte(0, 8'hA5, 0);
      send(0, 8'hA5, 1);
      wait_done("single");

      // req1 3-byte burst with req2 waiting (pointer=1).
      exp_byte(1, 8'h11, 0); exp_byte(1, 8'h12, 0); exp_byte(1, 8'h13, 0); exp_byte(2, 8'h21, 0);
      fork
         begin send(1, 8'h11, 0); send(1, 8'h12, 0); send(1, 8'h13, 1); end
         send(2, 8'h21, 1);
      join
      wait_done("burst3");

      // Move pointer to 2, then all four request at once: order 2,3,0,1.
      exp_byte(1, 8'h31, 0);
      send(1, 8'h31, 1);
      wait_done("ptr_to_2");
      exp_byte(2, 8'h42, 0); exp_byte(3, 8'h43, 0); exp_byte(0, 8'h40, 0); exp_byte(1, 8'h41, 0);
      fork
         send(0, 8'h40, 1);
         send(1, 8'h41, 1);
         send(2, 8'h42, 1);
         send(3, 8'h43, 1);
      join
      wait_done("all4");

      // Burst of 2 from req3 with valid dropped while holding the bus.
      exp_byte(3, 8'h50, 0); exp_byte(3, 8'h51, 0);
      send(3, 8'h50, 0);
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         chk("hold_cs", cs_n, 4'b0111);
         chk("hold_no_start", drv_start, 0);
      end
      send(3, 8'h51, 1);
      wait_done("hold");

      // Pointer to 3, then reset during req3's byte.
      exp_byte(2, 8'h65, 0);
      send(2, 8'h65, 1);
      wait_done("ptr_to_3");
      exp_tx.push_back('{d: 8'h70, id: 2'd3, err: 1'b0});
      send(3, 8'h70, 1);
      n = 0;
      while (!drv_en && n < 100) begin @(negedge clk); n++; end
      chk("xfer_reached", drv_en, 1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1 chk_reset_outs("midreset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_reset_outs("after_reset");
      repeat (3) @(negedge clk);
      chk("no_rsp_after_reset", rsp_valid, 0);
      // Pointer must be back at 0: req0 beats req3.
      exp_byte(0, 8'h80, 0); exp_byte(3, 8'h83, 0);
      fork
         send(0, 8'h80, 1);
         send(3, 8'h83, 1);
      join
      wait_done("ptr_reset");

`ifdef SPI_ARB_WATCHDOG_EN
      eng_stall = 1'b1;
      exp_byte(0, 8'h90, 1);
      send(0, 8'h90, 1);
      wait_done("watchdog");
      chk("wd_cs_released", cs_n, 4'hF);
      eng_stall = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
